// File: rtl/fb_write_ctrl_pkg.sv
// Shared definitions for the framebuffer write controller: geometry, register map,
// CTRL bit positions and fill-engine state encodings.
package fb_write_ctrl_pkg;

  localparam int FB_ADDR_WIDTH = 15;
  localparam int FB_DATA_WIDTH = 8;
  localparam int FB_DEPTH      = 19200;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_FILL = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_AUTOINC_BIT = 1;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fb_write_ctrl_fill_engine.sv
// Fill engine: sweeps every framebuffer address once with a latched colour,
// then pulses done for one cycle.
module fb_fill_engine
  import fb_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] colour,
  output logic                  fill_wr_en,
  output logic [ADDR_WIDTH-1:0] fill_wr_addr,
  output logic [DATA_WIDTH-1:0] fill_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  fill_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] colour_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL_IDLE;
      counter  <= '0;
      colour_q <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FILL_RUN) && (counter == LAST_ADDR);
      if (state == FILL_IDLE && start) begin
        counter  <= '0;
        colour_q <= colour;
      end else if (state == FILL_RUN) begin
        counter <= counter + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    fill_wr_en = 1'b0;
    case (state)
      FILL_IDLE: if (start) state_next = FILL_RUN;
      FILL_RUN: begin
        busy       = 1'b1;
        fill_wr_en = 1'b1;
        if (counter == LAST_ADDR) state_next = FILL_IDLE;
      end
      default: state_next = FILL_IDLE;
    endcase
  end

  assign fill_wr_addr = counter;
  assign fill_wr_data = colour_q;

endmodule

// File: rtl/fb_write_ctrl.sv
// Wishbone slave owning the framebuffer RAM write port; arbitrates CPU pixel
// writes through an auto-incrementing pointer against the hardware fill engine.
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [1:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  fb_wr_en,
  output logic [ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [DATA_WIDTH-1:0] fb_wr_data,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] pointer;
  logic                  autoinc;
  logic [DATA_WIDTH-1:0] fill_colour;
  logic                  start_pulse;
  logic                  cpu_wr_en;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic [DATA_WIDTH-1:0] cpu_wr_data;
  logic                  fill_wr_en;
  logic [ADDR_WIDTH-1:0] fill_wr_addr;
  logic [DATA_WIDTH-1:0] fill_wr_data;
  logic [31:0]           rd_data;
  logic                  req, stall, accept, wr;
  logic                  unused_wb_dat;

  // A DATA write waits without ack while the fill engine owns the port.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign stall  = wb_we_i & (wb_adr_i == REG_DATA) & fill_busy;
  assign accept = req & ~stall;
  assign wr     = accept & wb_we_i;

  assign unused_wb_dat = &{1'b0, wb_dat_i[31:ADDR_WIDTH]};

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      REG_CTRL: rd_data = {30'b0, fill_busy, autoinc};
      REG_FILL: rd_data = {{(32-DATA_WIDTH){1'b0}}, fill_colour};
      REG_ADDR: rd_data = {{(32-ADDR_WIDTH){1'b0}}, pointer};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      pointer     <= '0;
      autoinc     <= 1'b0;
      fill_colour <= '0;
      start_pulse <= 1'b0;
      cpu_wr_en   <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_wr_data <= '0;
    end else begin
      wb_ack_o    <= accept;
      wb_dat_o    <= (accept & ~wb_we_i) ? rd_data : '0;
      start_pulse <= 1'b0;
      cpu_wr_en   <= 1'b0;
      if (wr) begin
        case (wb_adr_i)
          REG_CTRL: begin
            autoinc     <= wb_dat_i[CTRL_AUTOINC_BIT];
            start_pulse <= wb_dat_i[CTRL_START_BIT] & ~fill_busy;
          end
          REG_FILL: fill_colour <= wb_dat_i[DATA_WIDTH-1:0];
          REG_ADDR: pointer     <= wb_dat_i[ADDR_WIDTH-1:0];
          REG_DATA: begin
            if (pointer <= LAST_ADDR) begin
              cpu_wr_en   <= 1'b1;
              cpu_wr_addr <= pointer;
              cpu_wr_data <= wb_dat_i[DATA_WIDTH-1:0];
              if (autoinc) pointer <= (pointer == LAST_ADDR) ? '0 : pointer + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fb_fill_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fill (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_pulse),
    .colour      (fill_colour),
    .fill_wr_en  (fill_wr_en),
    .fill_wr_addr(fill_wr_addr),
    .fill_wr_data(fill_wr_data),
    .busy        (fill_busy),
    .done        (fill_done)
  );

  always_comb begin
    fb_wr_en   = cpu_wr_en;
    fb_wr_addr = cpu_wr_addr;
    fb_wr_data = cpu_wr_data;
    if (fill_busy) begin
      fb_wr_en   = fill_wr_en;
      fb_wr_addr = fill_wr_addr;
      fb_wr_data = fill_wr_data;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl: a scoreboard queue of expected RAM writes
// is filled as accesses are issued and drained by a write-port monitor.
module tb_fb_write_ctrl;

  localparam int DEPTH = 19200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [1:0]  wb_adr_i = 2'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        fb_wr_en;
  logic [14:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        fill_busy;
  logic        fill_done;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles = 0;
  int done_pulses = 0;
  logic [22:0] exp_q[$];
  logic [7:0]  ram [0:32767];

  fb_write_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .fb_wr_en  (fb_wr_en),
    .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data),
    .fill_busy (fill_busy),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_wr_en) begin
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [22:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_wr_addr), 32'(e[22:8]));
          check("wr_data", 32'(fb_wr_data), 32'(e[7:0]));
        end
        ram[fb_wr_addr] = fb_wr_data;
      end
      if (fill_busy) begin
        busy_cycles++;
        check("busy_owns_port", 32'(fb_wr_en), 32'd1);
      end
      if (fill_done) done_pulses++;
    end
  end

  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                           input int max_cycles, output logic [31:0] rdat,
                           output logic ack_wr_en);
    bit got = 1'b0;
    rdat = '0;
    ack_wr_en = 1'b0;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        got = 1'b1;
        rdat = wb_dat_o;
        ack_wr_en = fb_wr_en;
      end
    end
    check("ack_within_budget", 32'(got), 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    logic        w;
    wb_access(1'b1, adr, dat, 8, r, w);
  endtask

  task automatic data_write(input logic [31:0] dat, input logic exp_en, input int budget);
    logic [31:0] r;
    logic        w;
    wb_access(1'b1, 2'd3, dat, budget, r, w);
    check("data_wr_coincident", 32'(w), 32'(exp_en));
  endtask

  task automatic read_check(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    logic        w;
    wb_access(1'b0, adr, 32'd0, 8, r, w);
    check(tag, r, exp);
  endtask

  task automatic push_fill(input logic [7:0] colour);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({15'(a), colour});
  endtask

  task automatic wait_fill_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (fill_done) seen = 1'b1;
    end
    check("fill_done_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted in the middle of a running fill.
    wb_write(2'd1, 32'h33);
    push_fill(8'h33);
    wb_write(2'd0, 32'h3);
    repeat (50) @(posedge clk);
    d0 = done_pulses;
    #3 rst_n = 1'b0;
    #1;
    check("rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_wr_addr", 32'(fb_wr_addr), 32'd0);
    check("rst_wr_data", 32'(fb_wr_data), 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    read_check("rst_ctrl_read", 2'd0, 32'd0);
    read_check("rst_fill_read", 2'd1, 32'd0);
    read_check("rst_addr_read", 2'd2, 32'd0);
    check("rst_no_done_pulse", 32'(done_pulses), 32'(d0));

    // Auto-increment across the top of the framebuffer.
    wb_write(2'd2, 32'd19198);
    wb_write(2'd0, 32'h2);
    read_check("ctrl_autoinc_read", 2'd0, 32'd1);
    exp_q.push_back({15'd19198, 8'hA1}); data_write(32'hA1, 1'b1, 8);
    exp_q.push_back({15'd19199, 8'hA2}); data_write(32'hA2, 1'b1, 8);
    exp_q.push_back({15'd0,     8'hA3}); data_write(32'hA3, 1'b1, 8);
    read_check("addr_after_wrap", 2'd2, 32'd1);
    read_check("data_reads_zero", 2'd3, 32'd0);

    // Out-of-range pointer: acked, no RAM write, pointer held.
    wb_write(2'd2, 32'd20000);
    data_write(32'h77, 1'b0, 8);
    read_check("addr_out_of_range", 2'd2, 32'd20000);

    // Full fill with colour E0.
    wb_write(2'd1, 32'hE0);
    read_check("fill_read", 2'd1, 32'hE0);
    push_fill(8'hE0);
    busy_cycles = 0;
    d0 = done_pulses;
    wb_write(2'd0, 32'h1);
    wait_fill_done(DEPTH + 10);
    @(negedge clk);
    check("fill1_busy_span", 32'(busy_cycles), 32'(DEPTH));
    check("fill1_one_done", 32'(done_pulses), 32'(d0 + 1));
    check("fill1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Second fill: busy-time register writes, then a stalled DATA write.
    push_fill(8'hE0);
    busy_cycles = 0;
    d0 = done_pulses;
    wb_write(2'd0, 32'h1);
    wb_write(2'd1, 32'h1C);
    wb_write(2'd0, 32'h1);
    read_check("ctrl_read_busy", 2'd0, 32'd2);
    wb_write(2'd2, 32'd7);
    exp_q.push_back({15'd7, 8'h55});
    data_write(32'h55, 1'b1, DEPTH + 20);
    check("stall_ack_after_done", 32'(done_pulses), 32'(d0 + 1));
    check("stall_busy_low_at_ack", 32'(fill_busy), 32'd0);
    check("fill2_busy_span", 32'(busy_cycles), 32'(DEPTH));
    check("fill2_sb_drained", 32'(exp_q.size()), 32'd0);
    check("ram7_final", 32'(ram[7]), 32'h55);
    read_check("addr_after_stall", 2'd2, 32'd7);

    // Next fill picks up the colour written while busy.
    push_fill(8'h1C);
    d0 = done_pulses;
    wb_write(2'd0, 32'h1);
    wait_fill_done(DEPTH + 10);
    @(negedge clk);
    check("fill3_one_done", 32'(done_pulses), 32'(d0 + 1));
    check("fill3_sb_drained", 32'(exp_q.size()), 32'd0);
    check("fill3_ram_last", 32'(ram[DEPTH-1]), 32'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
